// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch front-end: sequential word fetch with one outstanding
// memory request, a small FIFO of {pc, instr}, and flush/refetch on redirect.
module inst_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Redirect,
  input  logic [31:0]              RedirectPC,
  output logic                     ImReq,
  output logic [31:0]              ImAddr,
  input  logic                     ImValid,
  input  logic [31:0]              ImData,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [31:0]              OutInstr,
  output logic [31:0]              OutPC,
  output logic [31:0]              OutNextAddr,
  output logic [$clog2(DEPTH):0]   Count,
  output logic [1:0]               fetch_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc;
  logic [31:0]       req_pc;
  logic [31:0]       instr_mem [DEPTH];
  logic [31:0]       pc_mem    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              pop, push, req;
  logic [CNT_W:0]    free_w;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. Memory side: ImReq is the valid, the memory is always ready.
  // Output side: OutValid/OutReady; a redirect in the same cycle cancels it.
  assign OutValid    = (count_q != '0);
  assign OutInstr    = OutValid ? instr_mem[rd_ptr] : 32'h0;
  assign OutPC       = OutValid ? pc_mem[rd_ptr] : 32'h0;
  assign OutNextAddr = OutValid ? (pc_mem[rd_ptr] + 32'd4) : 32'h0;
  assign Count       = count_q;
  assign ImReq       = req;
  assign ImAddr      = fetch_pc;
  assign fetch_state = state_q;

  // Credit check counts the slot freed by a same-cycle pop and the slot
  // consumed by a same-cycle push, so the FIFO can never overflow.
  always_comb begin
    pop    = OutValid & OutReady & ~Redirect;
    push   = ImValid & (state_q == ST_WAIT) & ~Redirect;
    free_w = DEPTH_W + {{CNT_W{1'b0}}, pop}
                     - {1'b0, count_q}
                     - {{CNT_W{1'b0}}, push};
    req    = Reset & ~Redirect & (free_w != '0) &
             ((state_q == ST_IDLE) | ((state_q == ST_WAIT) & ImValid));
  end

  always_comb begin
    state_d = state_q;
    if (Redirect) begin
      if (ImValid || (state_q == ST_IDLE)) state_d = ST_IDLE;
      else                                 state_d = ST_DROP;
    end else if (req) begin
      state_d = ST_WAIT;
    end else if (ImValid && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (Redirect) begin
        fetch_pc <= RedirectPC;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count_q  <= '0;
      end else begin
        if (req) begin
          fetch_pc <= fetch_pc + 32'd4;
          req_pc   <= fetch_pc;
        end
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count_q <= count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge Clk) begin
    if (Reset && push) begin
      instr_mem[wr_ptr] <= ImData;
      pc_mem[wr_ptr]    <= req_pc;
    end
  end

  a_no_valid_in_idle: assert property (@(posedge Clk) disable iff (!Reset)
    !(ImValid && (state_q == ST_IDLE)));

  a_count_bound: assert property (@(posedge Clk) disable iff (!Reset)
    ({1'b0, count_q} <= DEPTH_W));

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed bench for inst_prefetch_buffer: a reactive variable-latency memory
// model per instance plus hand-computed expectations at each step.
module tb_inst_prefetch_buffer;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;
  int          lat;
  int          n_tests;
  int          n_fail;
  int          n_req;

  logic        im_req      [2];
  logic [31:0] im_addr     [2];
  logic        im_valid    [2];
  logic [31:0] im_data     [2];
  logic        out_valid   [2];
  logic [31:0] out_instr   [2];
  logic [31:0] out_pc      [2];
  logic [31:0] out_next    [2];
  logic [2:0]  count       [2];
  logic [1:0]  fsm_state   [2];

  logic        mem_busy    [2];
  int          mem_wcnt    [2];
  logic [31:0] mem_addr    [2];

  inst_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u0 (
    .Clk(clk), .Reset(rst_n), .Redirect(redirect), .RedirectPC(redirect_pc),
    .ImReq(im_req[0]), .ImAddr(im_addr[0]), .ImValid(im_valid[0]), .ImData(im_data[0]),
    .OutValid(out_valid[0]), .OutReady(out_ready), .OutInstr(out_instr[0]),
    .OutPC(out_pc[0]), .OutNextAddr(out_next[0]), .Count(count[0]),
    .fetch_state(fsm_state[0])
  );

  inst_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u1 (
    .Clk(clk), .Reset(rst_n), .Redirect(1'b0), .RedirectPC(32'h0),
    .ImReq(im_req[1]), .ImAddr(im_addr[1]), .ImValid(im_valid[1]), .ImData(im_data[1]),
    .OutValid(out_valid[1]), .OutReady(1'b1), .OutInstr(out_instr[1]),
    .OutPC(out_pc[1]), .OutNextAddr(out_next[1]), .Count(count[1]),
    .fetch_state(fsm_state[1])
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request/response seen at this edge, then update the
  // memory model (u0 uses latency lat, u1 always latency 1).
  task automatic tick();
    logic        req [2];
    logic [31:0] adr [2];
    logic        vld [2];
    for (int i = 0; i < 2; i++) begin
      req[i] = im_req[i];
      adr[i] = im_addr[i];
      vld[i] = im_valid[i];
    end
    @(posedge clk);
    #1;
    if (req[0] && rst_n) n_req++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mem_busy[i] = 1'b0;
      end else begin
        if (vld[i]) mem_busy[i] = 1'b0;
        if (req[i]) begin
          mem_busy[i] = 1'b1;
          mem_addr[i] = adr[i];
          mem_wcnt[i] = ((i == 0) ? lat : 1) - 1;
        end else if (mem_busy[i] && mem_wcnt[i] > 0) begin
          mem_wcnt[i] = mem_wcnt[i] - 1;
        end
      end
      im_valid[i] = mem_busy[i] && (mem_wcnt[i] == 0);
      im_data[i]  = mem_busy[i] ? ~mem_addr[i] : 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_req = 0;
    #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_req = 0;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1; lat = 1;
    for (int i = 0; i < 2; i++) begin
      im_valid[i] = 1'b0; im_data[i] = 32'h0; mem_busy[i] = 1'b0;
      mem_wcnt[i] = 0; mem_addr[i] = 32'h0;
    end

    // Reset, then streaming with latency 1; u1 covers the wrap at 2^32
    tick(); tick();
    check("rst_count",   32'(count[0]),     32'd0);
    check("rst_ovalid",  32'(out_valid[0]), 32'd0);
    check("rst_imreq",   32'(im_req[0]),    32'd0);
    check("rst_outpc",   out_pc[0],         32'h0);
    check("rst_instr",   out_instr[0],      32'h0);
    check("rst_next",    out_next[0],       32'h0);
    check("rst_imreq1",  32'(im_req[1]),    32'd0);
    rst_n = 1'b1; #1;
    check("rel_imreq",   32'(im_req[0]),    32'd1);
    check("rel_addr",    im_addr[0],        32'h0);
    check("rel_addr1",   im_addr[1],        32'hFFFF_FFF8);
    tick();
    check("s1_ovalid_e1", 32'(out_valid[0]), 32'd0);
    check("s1_addr_e1",   im_addr[0],        32'h4);
    check("s1_addr1_e1",  im_addr[1],        32'hFFFF_FFFC);
    tick();
    check("s1_ovalid_e2", 32'(out_valid[0]), 32'd1);
    check("s1_pc_e2",     out_pc[0],         32'h0);
    check("s1_next_e2",   out_next[0],       32'h4);
    check("s1_instr_e2",  out_instr[0],      32'hFFFF_FFFF);
    check("s1_addr_e2",   im_addr[0],        32'h8);
    check("s1_count_e2",  32'(count[0]),     32'd1);
    check("s1_pc1_e2",    out_pc[1],         32'hFFFF_FFF8);
    check("s1_addr1_e2",  im_addr[1],        32'h0);
    tick();
    check("s1_pc_e3",     out_pc[0],         32'h4);
    check("s1_next_e3",   out_next[0],       32'h8);
    check("s1_addr_e3",   im_addr[0],        32'hC);
    check("s1_req_e3",    32'(im_req[0]),    32'd1);
    check("s1_pc1_e3",    out_pc[1],         32'hFFFF_FFFC);
    check("s1_next1_e3",  out_next[1],       32'h0);
    check("s1_instr1_e3", out_instr[1],      32'h3);

    // Back-pressure: fill to DEPTH, then one pop with a same-cycle request
    out_ready = 1'b0; lat = 1;
    do_reset();
    repeat (5) tick();
    check("s2_count_full", 32'(count[0]),    32'd4);
    check("s2_req_full",   32'(im_req[0]),   32'd0);
    check("s2_nreq",       32'(n_req),       32'd4);
    check("s2_pc_head",    out_pc[0],        32'h0);
    tick();
    check("s2_count_hold", 32'(count[0]),    32'd4);
    check("s2_req_hold",   32'(im_req[0]),   32'd0);
    out_ready = 1'b1; #1;
    check("s2_req_pop",    32'(im_req[0]),   32'd1);
    check("s2_addr_pop",   im_addr[0],       32'h10);
    tick();
    out_ready = 1'b0; #1;
    check("s2_pc_after",   out_pc[0],        32'h4);
    check("s2_count_after", 32'(count[0]),   32'd3);
    check("s2_req_after",  32'(im_req[0]),   32'd0);
    tick();
    check("s2_count_refill", 32'(count[0]),  32'd4);

    // Latency 3: redirect while the 0x8 request is outstanding
    out_ready = 1'b1; lat = 3;
    do_reset();
    repeat (7) tick();
    check("s3_pc_pre",     out_pc[0],        32'h4);
    check("s3_state_pre",  32'(fsm_state[0]), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h100; #1;
    check("s3_req_redir",  32'(im_req[0]),   32'd0);
    tick();
    redirect = 1'b0; #1;
    check("s3_count_flush", 32'(count[0]),   32'd0);
    check("s3_ovalid_flush", 32'(out_valid[0]), 32'd0);
    check("s3_state_drop", 32'(fsm_state[0]), 32'd2);
    check("s3_req_drop",   32'(im_req[0]),   32'd0);
    tick();
    check("s3_state_drop2", 32'(fsm_state[0]), 32'd2);
    check("s3_req_drop2",  32'(im_req[0]),   32'd0);
    tick();
    check("s3_state_idle", 32'(fsm_state[0]), 32'd0);
    check("s3_req_new",    32'(im_req[0]),   32'd1);
    check("s3_addr_new",   im_addr[0],       32'h100);
    check("s3_ovalid_new", 32'(out_valid[0]), 32'd0);
    repeat (4) tick();
    check("s3_ovalid_out", 32'(out_valid[0]), 32'd1);
    check("s3_pc_out",     out_pc[0],        32'h100);
    check("s3_instr_out",  out_instr[0],     ~32'h100);

    // Redirect in the same cycle as the 0x8 response, Count=2, OutReady=1
    out_ready = 1'b0; lat = 1;
    do_reset();
    repeat (3) tick();
    check("s4_count_pre",  32'(count[0]),    32'd2);
    check("s4_pc_pre",     out_pc[0],        32'h0);
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40; #1;
    check("s4_req_redir",  32'(im_req[0]),   32'd0);
    tick();
    redirect = 1'b0; #1;
    check("s4_count_flush", 32'(count[0]),   32'd0);
    check("s4_ovalid_flush", 32'(out_valid[0]), 32'd0);
    check("s4_state_idle", 32'(fsm_state[0]), 32'd0);
    check("s4_req_new",    32'(im_req[0]),   32'd1);
    check("s4_addr_new",   im_addr[0],       32'h40);
    repeat (2) tick();
    check("s4_ovalid_out", 32'(out_valid[0]), 32'd1);
    check("s4_pc_out",     out_pc[0],        32'h40);
    check("s4_instr_out",  out_instr[0],     ~32'h40);
    check("s4_count_out",  32'(count[0]),    32'd1);

    // Reset while a request is outstanding with Count=3
    out_ready = 1'b0; lat = 1;
    do_reset();
    repeat (4) tick();
    check("s6_count_pre",  32'(count[0]),    32'd3);
    check("s6_state_pre",  32'(fsm_state[0]), 32'd1);
    rst_n = 1'b0; #1;
    check("s6_req_inrst",  32'(im_req[0]),   32'd0);
    tick();
    check("s6_count_rst",  32'(count[0]),    32'd0);
    check("s6_ovalid_rst", 32'(out_valid[0]), 32'd0);
    check("s6_state_rst",  32'(fsm_state[0]), 32'd0);
    rst_n = 1'b1; #1;
    check("s6_req_rel",    32'(im_req[0]),   32'd1);
    check("s6_addr_rel",   im_addr[0],       32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
